routing_arbiter: RTL and testbench
==================================

# routing_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit routing path among four requesters. It selects a winner each cycle the output stage can accept data. It drives the 4:1 data select with the winner's index and registers the selected word into a single-entry valid/ready output stage. Multi-beat packets (`req_last` framing) hold the grant until the last beat is accepted, so packets are never interleaved.

## Interface
- WIDTH, 4, data width of each requester word and of the output.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester valid; bit i = requester i.
- req_last  in  4  per-requester last-beat flag; qualified by req_valid[i].
- req_data  in  4*WIDTH  requester words; requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  4  one-hot or zero; beat i accepted when req_valid[i] & req_ready[i].
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered selected word.
- out_last  out  1  registered last flag of that beat.
- out_src  out  2  registered index of the source requester.
- out_ready  in  1  downstream accepts; transfer when out_valid & out_ready.
- locked  out  1  high while in LOCK state (mid-packet).

## Operation
- load = !out_valid | out_ready: the output register can take a new beat this cycle.
- State machine ARB/LOCK plus a 2-bit round-robin pointer `ptr` and a 2-bit `lock_src`.
- In ARB, the candidate is the first i with req_valid[i] set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- In LOCK, the only candidate is lock_src. Other requesters are ignored even if valid.
- req_ready is combinational: req_ready[winner] = load & !rst when a candidate exists. All other bits are 0.
- On an accepted beat: out_data <= req_data[winner], out_last <= req_last[winner], out_src <= winner, out_valid <= 1.
- On load with no candidate: out_valid <= 0. Data, last and src hold their values.
- Accepted beat with last=0 in ARB: go to LOCK, lock_src <= winner, ptr unchanged.
- Accepted beat with last=1, in either state: go to ARB, ptr <= winner+1 (mod 4), wrapping 3 to 0.
- In LOCK with req_valid[lock_src]=0: no transfer, stay in LOCK. Bubbles are allowed mid-packet.
- Simultaneous out_ready and new beat: the old beat leaves and the new beat loads in the same cycle (full throughput).
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, locked=0, ptr=0, state=ARB, req_ready=0.
- Reset mid-packet: state returns to ARB and the partial packet is dropped. Upstream must restart it.

## Timing
- Latency: 1 cycle from req_valid & req_ready to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- out_valid=1 & out_ready=0: out_* hold stable and req_ready=0 (load=0).
- req_ready depends combinationally on req_valid, out_valid, out_ready and state. No path from out_ready to out_* within a cycle.
- A grant is never revoked mid-packet. A packet of N beats occupies at least N consecutive accepted beats from one source.

## Structure
- Shared package: state encoding (ARB=1'b0, LOCK=1'b1), NUM_REQ=4, REQ_IDX_W=2.
- The data select is the existing `routing_unit` 4:1 selector, instantiated with WIDTH, sel=winner, d0..d3 = req_data slices.
- Round-robin priority pick (ptr plus valid vector to winner and found) is plain combinational logic in this module. It is not a separate sub-module.

## Test plan
- Reset then single beat: req_valid=4'b0100, req_last=4'b0100, data2=4'hA, out_ready=1. Expect req_ready=4'b0100; next cycle out_valid=1, out_data=A, out_src=2, out_last=1; ptr becomes 3.
- Fairness: all four valid with last=1 continuously, out_ready=1, ptr=0. Expect out_src sequence 0,1,2,3,0, one beat/cycle.
- Packet lock: req0 sends 3 beats (last on beat 3) while req1 stays valid. Expect out_src=0 for 3 beats, locked=1 after beat 1 and during beat 2, then out_src=1 next; req_ready[1]=0 throughout the packet.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and req3 valid. Expect out_data/out_src stable, req_ready=0; on out_ready=1, old beat transfers and req3 loads the same cycle.
- Wrap-around: ptr=3, req_valid=4'b1001, last=1. Expect winner 3, then ptr=0 and winner 0.
- Reset mid-packet: assert rst during LOCK with out_valid=1. Next cycle out_valid=0, locked=0, ptr=0; with req_valid=4'b0010, first grant is to req1.

Source files
------------

// File: rtl/routing_arbiter_pkg.sv
// Shared types and constants for the four-way routing arbiter.
// State encoding and requester index width.
package routing_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/routing_unit.sv
// 4:1 word selector used by the routing path.
// Purely combinational; sel picks one of d0..d3.
module routing_unit #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/routing_arbiter.sv
// Round-robin arbiter sharing one routing path among four requesters.
// Multi-beat packets hold the grant until their last beat is accepted.
module routing_arbiter
  import routing_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  input  logic [3:0]           req_last,
  input  logic [4*WIDTH-1:0]   req_data,
  output logic [3:0]           req_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [1:0]           out_src,
  input  logic                 out_ready,
  output logic                 locked
);

  state_t               state;
  state_t               state_d;
  logic [REQ_IDX_W-1:0] ptr;
  logic [REQ_IDX_W-1:0] ptr_d;
  logic [REQ_IDX_W-1:0] lock_src;
  logic [REQ_IDX_W-1:0] lock_src_d;
  logic [REQ_IDX_W-1:0] winner;
  logic                 found;
  logic                 load;
  logic                 accept;
  logic [WIDTH-1:0]     sel_data;

  assign load   = ~out_valid | out_ready;
  assign accept = found & load & ~rst;
  assign locked = (state == LOCK);

  // Scan from ptr+3 down to ptr so the nearest valid one wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    if (state == LOCK) begin
      found  = req_valid[lock_src];
      winner = lock_src;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[ptr + 2'(k)]) begin
          found  = 1'b1;
          winner = ptr + 2'(k);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    lock_src_d = lock_src;
    if (accept) begin
      if (req_last[winner]) begin
        state_d = ARB;
        ptr_d   = winner + 2'd1;
      end else if (state == ARB) begin
        state_d    = LOCK;
        lock_src_d = winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      ptr      <= '0;
      lock_src <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      lock_src <= lock_src_d;
    end
  end

  routing_unit #(
    .WIDTH (WIDTH)
  ) u_sel (
    .sel (winner),
    .d0  (req_data[0*WIDTH +: WIDTH]),
    .d1  (req_data[1*WIDTH +: WIDTH]),
    .d2  (req_data[2*WIDTH +: WIDTH]),
    .d3  (req_data[3*WIDTH +: WIDTH]),
    .y   (sel_data)
  );

  // Data, last and src hold when a load slot finds no candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= req_last[winner];
        out_src   <= winner;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_routing_arbiter.sv
// Self-checking bench for routing_arbiter: vector table,
// hand-written corner sequences and a randomized reference model.
module tb_routing_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_last;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;
  logic           locked;

  int total = 0;
  int bad   = 0;

  routing_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic [3:0] rl;
    logic       ordy;
    logic [3:0] rr;
    logic       ov;
    logic [1:0] src;
    logic       last;
    logic       lk;
  } vec_t;

  vec_t tbl[$];

  logic [W-1:0] dat [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  bit           m_lock;
  int           m_ptr;
  int           m_lsrc;
  bit           m_ov;
  logic [W-1:0] m_data;
  bit           m_last;
  int           m_src;

  function automatic int m_cand(input logic [3:0] rv);
    if (m_lock) return rv[m_lsrc] ? m_lsrc : -1;
    for (int k = 0; k < 4; k++)
      if (rv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_lock = 0; m_ptr = 0; m_lsrc = 0;
    m_ov = 0; m_data = '0; m_last = 0; m_src = 0;
  endtask

  initial begin
    int c;
    bit ld;
    logic [3:0] exp_rr;

    dat[0] = 8'h10; dat[1] = 8'h21;
    dat[2] = 8'h0A; dat[3] = 8'h43;
    req_data = {dat[3], dat[2], dat[1], dat[0]};

    //           rst  rv       rl       rdy  rr       ov  src  last lk
    tbl.push_back('{0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 2'd2, 1, 0});
    tbl.push_back('{0, 4'b1001, 4'b1111, 1, 4'b1000, 1, 2'd3, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 2'd1, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2'd2, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2'd3, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 1, 0});
    tbl.push_back('{1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 4'b0011, 4'b0000, 1, 4'b0001, 1, 2'd0, 0, 1});
    tbl.push_back('{0, 4'b0010, 4'b0010, 1, 4'b0000, 0, 2'd0, 0, 1});
    tbl.push_back('{0, 4'b0011, 4'b0010, 1, 4'b0001, 1, 2'd0, 0, 1});
    tbl.push_back('{0, 4'b0011, 4'b0011, 1, 4'b0001, 1, 2'd0, 1, 0});
    tbl.push_back('{0, 4'b0011, 4'b0011, 1, 4'b0010, 1, 2'd1, 1, 0});

    rst = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 1'b1;
    #1;
    cyc();
    chk("rst rr", 32'(req_ready), 32'h0);
    chk("rst ov", 32'(out_valid), 32'h0);
    chk("rst data", 32'(out_data), 32'h0);
    chk("rst src", 32'(out_src), 32'h0);
    chk("rst last", 32'(out_last), 32'h0);
    chk("rst lk", 32'(locked), 32'h0);

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      req_valid = tbl[i].rv;
      req_last  = tbl[i].rl;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("t%0d rr", i), 32'(req_ready), 32'(tbl[i].rr));
      cyc();
      chk($sformatf("t%0d ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("t%0d last", i), 32'(out_last), 32'(tbl[i].last));
      chk($sformatf("t%0d lk", i), 32'(locked), 32'(tbl[i].lk));
      if (tbl[i].ov) begin
        chk($sformatf("t%0d src", i), 32'(out_src), 32'(tbl[i].src));
        chk($sformatf("t%0d data", i), 32'(out_data),
            32'(dat[tbl[i].src]));
      end
    end

    // Backpressure: beat from req1 held while req3 waits.
    rst = 1'b0;
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp rr", 32'(req_ready), 32'h0);
      cyc();
      chk("bp ov", 32'(out_valid), 32'h1);
      chk("bp src", 32'(out_src), 32'h1);
      chk("bp data", 32'(out_data), 32'(dat[1]));
    end
    out_ready = 1'b1;
    #1;
    chk("bp rel rr", 32'(req_ready), 32'h8);
    cyc();
    chk("bp rel src", 32'(out_src), 32'h3);
    chk("bp rel data", 32'(out_data), 32'(dat[3]));
    chk("bp rel ov", 32'(out_valid), 32'h1);

    // Reset mid-packet with ptr moved off zero.
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    cyc();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    #1;
    chk("mp rr", 32'(req_ready), 32'h8);
    cyc();
    chk("mp lk", 32'(locked), 32'h1);
    chk("mp ov", 32'(out_valid), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mp rst ov", 32'(out_valid), 32'h0);
    chk("mp rst lk", 32'(locked), 32'h0);
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    #1;
    chk("mp ptr0 rr", 32'(req_ready), 32'h1);
    cyc();
    chk("mp ptr0 src", 32'(out_src), 32'h0);
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    #1;
    chk("mp req1 rr", 32'(req_ready), 32'h2);
    cyc();

    // Randomized run against the reference model.
    rst = 1'b1;
    cyc();
    m_reset();
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 4'($urandom);
      req_last  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      req_data  = 32'($urandom);
      #1;
      ld = !m_ov || out_ready;
      c  = m_cand(req_valid);
      exp_rr = '0;
      if (c >= 0 && ld && !rst) exp_rr[c] = 1'b1;
      chk($sformatf("r%0d rr", n), 32'(req_ready), 32'(exp_rr));
      if (rst) begin
        m_reset();
      end else if (ld) begin
        if (c >= 0) begin
          m_ov   = 1;
          m_data = req_data[c*W +: W];
          m_last = req_last[c];
          m_src  = c;
          if (req_last[c]) begin
            m_lock = 0;
            m_ptr  = (c + 1) % 4;
          end else begin
            m_lock = 1;
            m_lsrc = c;
          end
        end else begin
          m_ov = 0;
        end
      end
      cyc();
      chk($sformatf("r%0d ov", n), 32'(out_valid), 32'(m_ov));
      chk($sformatf("r%0d data", n), 32'(out_data), 32'(m_data));
      chk($sformatf("r%0d last", n), 32'(out_last), 32'(m_last));
      chk($sformatf("r%0d src", n), 32'(out_src), 32'(m_src));
      chk($sformatf("r%0d lk", n), 32'(locked), 32'(m_lock));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
